// File: rtl/uart_tx.sv
// UART transmitter: 4-entry byte FIFO feeding an 8N1 serializer with
// OVS clocks per bit and GAP idle bit periods after each stop bit.
module uart_tx #(
    parameter int unsigned OVS = 16,
    parameter int unsigned GAP = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       WR,
    output logic       FULL,
    output logic       BUSY,
    output logic       OVF,
    output logic       TX
);
    localparam int unsigned TICK_W = $clog2(OVS);
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP != 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAPW
    } state_t;

    state_t            state, state_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [2:0]        bit_idx, bit_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [7:0]        shift, shift_n;
    logic              tx_n;
    logic              ovf_n;

    logic [7:0]        mem [4];
    logic [1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_n;

    logic              push_c, pop_c, frame_end_c, tick_last_c;

    // Next-state, FIFO handshake and serial-line value
    always_comb begin
        state_n     = state;
        tick_n      = tick;
        bit_n       = bit_idx;
        gap_n       = gap_cnt;
        shift_n     = shift;
        tx_n        = TX;
        pop_c       = 1'b0;
        frame_end_c = 1'b0;
        tick_last_c = (tick == TICK_LAST);

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
            end
            S_START: begin
                if (tick_last_c) begin
                    state_n = S_DATA;
                    tick_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift[0];
                end else begin
                    tick_n = TICK_W'(tick + 1'b1);
                end
            end
            S_DATA: begin
                if (tick_last_c) begin
                    tick_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift[7:1]};
                        bit_n   = 3'(bit_idx + 3'd1);
                        tx_n    = shift[1];
                    end
                end else begin
                    tick_n = TICK_W'(tick + 1'b1);
                end
            end
            S_STOP: begin
                if (tick_last_c) begin
                    tick_n = '0;
                    if (GAP != 0) begin
                        state_n = S_GAPW;
                        gap_n   = '0;
                    end else begin
                        frame_end_c = 1'b1;
                    end
                end else begin
                    tick_n = TICK_W'(tick + 1'b1);
                end
            end
            S_GAPW: begin
                if (tick_last_c) begin
                    tick_n = '0;
                    if (gap_cnt == GAP_LAST) begin
                        frame_end_c = 1'b1;
                    end else begin
                        gap_n = GAP_W'(gap_cnt + 1'b1);
                    end
                end else begin
                    tick_n = TICK_W'(tick + 1'b1);
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // A queued byte starts its frame straight away, even from the last gap/stop cycle
        if ((state == S_IDLE || frame_end_c) && count != '0) begin
            pop_c   = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            tick_n  = '0;
            state_n = S_START;
        end else if (frame_end_c) begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
        end

        // Fullness is judged before this edge's pop, so a write racing a pop is dropped
        push_c  = WR && (count != DEPTH);
        ovf_n   = OVF || (WR && (count == DEPTH));
        count_n = CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shift   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            TX      <= 1'b1;
            FULL    <= 1'b0;
            BUSY    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_n;
            gap_cnt <= gap_n;
            shift   <= shift_n;
            count   <= count_n;
            TX      <= tx_n;
            OVF     <= ovf_n;
            FULL    <= (count_n == DEPTH);
            BUSY    <= (state_n != S_IDLE) || (count_n != '0);
            if (push_c) wr_ptr <= 2'(wr_ptr + 2'd1);
            if (pop_c)  rd_ptr <= 2'(rd_ptr + 2'd1);
        end
    end

    // FIFO storage; contents are meaningless once count is cleared
    always_ff @(posedge CLK) begin
        if (!RST && push_c) mem[wr_ptr] <= DIN;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: a line monitor rebuilds each frame
// from the expected byte and checks every cycle of it.
module tb_uart_tx;
    localparam int OVS   = 16;
    localparam int GAP   = 1;
    localparam int FRAME = (10 + GAP) * OVS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       wr  = 1'b0;
    logic       full, busy, ovf, tx;

    logic [7:0] din0 = '0;
    logic       wr0  = 1'b0;
    logic       full0, busy0, ovf0, tx0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q [$];

    bit         mon_active = 1'b0;
    bit         mon_have   = 1'b0;
    logic [7:0] mon_byte   = '0;
    int         mon_idx    = 0;
    int         mon_err    = 0;

    uart_tx #(.OVS(OVS), .GAP(GAP)) dut (
        .CLK(clk), .RST(rst), .DIN(din), .WR(wr),
        .FULL(full), .BUSY(busy), .OVF(ovf), .TX(tx)
    );

    uart_tx #(.OVS(OVS), .GAP(0)) dut0 (
        .CLK(clk), .RST(rst), .DIN(din0), .WR(wr0),
        .FULL(full0), .BUSY(busy0), .OVF(ovf0), .TX(tx0)
    );

    always #5 clk = ~clk;

    // Line level expected at cycle idx of a frame carrying byte b
    function automatic logic exp_level(input logic [7:0] b, input int idx);
        int k;
        k = idx / OVS;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One write cycle starting at posedge+1; the byte is expected if FULL is low
    task automatic wr_cycle(input logic [7:0] d);
        din = d;
        wr  = 1'b1;
        if (!full) exp_q.push_back(d);
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy && exp_q.size() == 0 && !mon_active) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("wait_idle_timeout", int'(done), 1);
    endtask

    // Monitor: pops the expected byte at each start bit and checks the whole frame
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            mon_idx++;
            if (tx !== exp_level(mon_byte, mon_idx)) mon_err++;
            if (mon_idx == FRAME - 1) begin
                mon_active = 1'b0;
                n_tests++;
                if (!mon_have || mon_err != 0) begin
                    n_fail++;
                    $display("FAIL frame: byte %02h expected=%0d bad_cycles=%0d", mon_byte, mon_have, mon_err);
                end
            end
        end else if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_idx    = 0;
            mon_err    = 0;
            if (exp_q.size() > 0) begin
                mon_have = 1'b1;
                mon_byte = exp_q.pop_front();
            end else begin
                mon_have = 1'b0;
                mon_byte = '0;
            end
        end
    end

    initial begin
        int k, drops, lows, hi;
        bit fb, seen;

        // Reset state
        idle_cycles(3);
        rst = 1'b0;
        check("rst_tx", int'(tx), 1);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        idle_cycles(5);
        check("idle_tx", int'(tx), 1);

        // Single 0xA5: latency and BUSY duration
        wr_cycle(8'hA5);
        check("busy_after_wr", int'(busy), 1);
        @(negedge clk);
        check("tx_high_at_wr_edge", int'(tx), 1);
        @(negedge clk);
        check("tx_low_next_edge", int'(tx), 0);
        k = 0;
        for (int j = 1; j < 400; j++) begin
            @(negedge clk);
            if (!busy) begin
                k = j;
                break;
            end
        end
        check("busy_fall_cycles", k, FRAME);
        @(posedge clk);
        #1;
        wait_idle(400);

        // Four bytes queued behind a frame in progress fill the FIFO
        wr_cycle(8'hC3);
        idle_cycles(5);
        wr_cycle(8'h00);
        wr_cycle(8'hFF);
        wr_cycle(8'h5A);
        wr_cycle(8'h81);
        check("full_after_four", int'(full), 1);
        check("no_ovf_yet", int'(ovf), 0);
        wait_idle(2000);

        // Five back-to-back writes from idle, then an overflowing sixth
        for (int i = 0; i < 5; i++) wr_cycle(8'($urandom));
        check("full_after_five", int'(full), 1);
        wr_cycle(8'hEE);
        check("ovf_set", int'(ovf), 1);
        check("full_held", int'(full), 1);

        // Hammer WR while full: writes racing a pop must be dropped
        drops = 0;
        for (int i = 0; i < 500; i++) begin
            fb = full;
            wr_cycle(8'($urandom));
            if (fb && !full) drops++;
        end
        check("full_drops_on_pop", int'(drops > 0), 1);
        check("ovf_sticky", int'(ovf), 1);
        wait_idle(2000);

        // Reset in the middle of data bit 3 of 0x3C
        wr_cycle(8'h3C);
        repeat (OVS * 4 + 6) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_full", int'(full), 0);
        check("abort_ovf", int'(ovf), 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("no_tx_after_abort", lows, 0);
        @(posedge clk);
        #1;

        // Random bytes with random spacing
        for (int i = 0; i < 12; i++) begin
            wr_cycle(8'($urandom));
            idle_cycles($urandom_range(0, 200));
        end
        wait_idle(3000);

        // GAP=0: stop bit then immediate next start bit
        din0 = 8'h3C;
        wr0  = 1'b1;
        idle_cycles(2);
        wr0  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!tx0) begin
                seen = 1'b1;
                break;
            end
        end
        check("gap0_start_seen", int'(seen), 1);
        repeat (8 * OVS + OVS - 1) @(negedge clk);
        check("gap0_bit7_low", int'(tx0), 0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx0) hi++;
            else break;
        end
        check("gap0_high_cycles", hi, OVS);
        repeat (OVS / 2) @(negedge clk);
        check("gap0_second_start", int'(tx0), 0);
        repeat (FRAME + 20) @(negedge clk);
        check("gap0_busy_done", int'(busy0), 0);
        check("gap0_full", int'(full0), 0);
        check("gap0_ovf", int'(ovf0), 0);
        check("gap0_tx_idle", int'(tx0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVS, default 16: CLK cycles per bit period; legal range 2..256.
REQ-002 Parameter GAP, default 1: idle-high bit periods inserted after each stop bit; legal range 0..15.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 DIN  input  8  byte to transmit; sampled only when WR=1.
REQ-006 WR  input  1  write strobe; one byte is offered per cycle WR=1.
REQ-007 FULL  output  1  FIFO holds 4 bytes; registered.
REQ-008 BUSY  output  1  frame in progress or FIFO non-empty; registered.
REQ-009 OVF  output  1  sticky flag: a write was dropped.
REQ-010 TX  output  1  serial line; idle high; registered, no combinational path from any input.

Function
REQ-011 The block SHALL contain a 4-entry byte FIFO with a 3-bit occupancy count (0..4) and 2-bit wrapping read/write pointers.
REQ-012 A write with WR=1 and FULL=0 SHALL store DIN and increment the count at that edge.
REQ-013 A write with WR=1 and FULL=1 SHALL be dropped and SHALL set OVF, even if a pop occurs in the same cycle.
REQ-014 A simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-015 FULL SHALL equal (count==4), and BUSY SHALL equal (state!=IDLE or count!=0), both evaluated from post-edge state.
REQ-016 The FSM states SHALL be IDLE, START, DATA, STOP and GAPW.
REQ-017 The block SHALL use a tick counter 0..OVS-1 and a 3-bit bit index 0..7.
REQ-018 IDLE: TX=1; when count!=0, the block SHALL pop the head byte into an 8-bit shift register, drive TX=0, clear the tick counter and go to START at the same edge.
REQ-019 START: TX=0 SHALL be held for exactly OVS cycles; the FSM then goes to DATA with bit index 0.
REQ-020 DATA: TX SHALL carry shift[0], with each bit held OVS cycles, LSB first; the shift register shifts right at each bit boundary; the FSM goes to STOP after bit 7.
REQ-021 STOP: TX=1 SHALL be held for OVS cycles, after which the FSM goes to GAPW if GAP>0, else to IDLE.
REQ-022 GAPW: TX=1 SHALL be held for GAP*OVS cycles, after which the FSM goes to IDLE.
REQ-023 Total frame period SHALL be (10+GAP)*OVS cycles.
REQ-024 With the FIFO non-empty at frame end, the next start bit SHALL begin on the edge following the final GAPW/STOP cycle, with no additional IDLE cycle.
REQ-025 Latency: for a write accepted at edge E0 with IDLE and an empty FIFO, TX SHALL go low at edge E0+1.
REQ-026 Writes during a frame SHALL NOT disturb the frame in progress; the byte being transmitted is held in the shift register, not the FIFO.
REQ-027 OVF SHALL remain set until RST.
REQ-028 The frame format (1 start, 8 data LSB-first, 1 stop, 16 CLK per bit at default) SHALL be decodable by the team's 16x-oversampling UART receiver on the same CLK.

Reset
REQ-029 On RST=1 at an edge, the block SHALL set TX=1, FULL=0, BUSY=0, OVF=0, FSM=IDLE, count=0, pointers=0, tick counter=0, bit index=0 and shift register=0.
REQ-030 Reset SHALL take priority over WR and over any frame in progress.
REQ-031 A frame aborted by reset SHALL NOT be resumed, and FIFO contents are discarded.
REQ-032 After RST is released, TX SHALL stay 1 until a new byte is written.

Verification
REQ-033 Single byte 0xA5, OVS=16, GAP=1: TX low 1 cycle after WR, then 16-cycle bits 0,1,0,1,0,0,1,0,1,1; BUSY falls 176 cycles after TX falls.
REQ-034 Loopback into the 16x receiver: bytes 0x00, 0xFF, 0x5A, 0x81 written back-to-back -> receiver output shows each byte in order; FULL=1 after the fourth write.
REQ-035 Five writes on consecutive cycles from empty/IDLE: first byte popped at the second edge, so all five accepted, FULL=1 -> a sixth write is dropped and OVF=1; exactly five frames are emitted.
REQ-036 RST asserted during data bit 3 of 0x3C -> TX=1, BUSY=0 and FULL=0 after that edge; no further low levels on TX.
REQ-037 GAP=0, two bytes queued: stop bit of frame 1 followed immediately by start bit of frame 2 -> exactly 16 high cycles between the last data bit and the next start bit when that data bit is 0.
REQ-038 Write on the cycle the FIFO goes 4->3 by pop while FULL=1 -> write dropped, OVF=1, count=3.
